// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: WIDTH-generic pipelined carry-select adder/subtractor.
// One BLOCK-bit slice is resolved per stage; the carry between slices is
// always taken from a register, so no carry ripples across a block boundary
// within a cycle. Operands are skewed: each stage carries only the operand
// bits still to be processed, plus the result bits already finished.
// The whole pipe advances or holds as one unit under a single stall signal.
module csa_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLOCK;

    logic             w_stall;
    logic             w_in_xfer;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c_eff;
    logic             r_ovf;

    // Subtraction is a + ~b + 1; a borrow-in cancels that +1.
    assign w_b_eff   = sub ? ~b : b;
    assign w_c_eff   = cin ^ sub;

    assign w_stall   = out_valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign w_in_xfer = in_valid & in_ready;

    generate
        if (BLOCK < 1 || BLOCK > WIDTH) begin : g_bad_block
            $error("csa_pipe_adder: BLOCK must satisfy 1 <= BLOCK <= WIDTH");
        end else if (WIDTH % BLOCK != 0) begin : g_bad_width
            $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK");
        end

        for (genvar k = 0; k < NBLK; k++) begin : g_stg
            // RW: operand bits still unprocessed on entry to this stage (this block included)
            // SW: result bits complete on exit from this stage
            localparam int RW = WIDTH - k * BLOCK;
            localparam int SW = (k + 1) * BLOCK;

            logic [RW-1:0]  w_a_rem;
            logic [RW-1:0]  w_b_rem;
            logic           w_ci;
            logic           w_vld_in;
            logic [BLOCK:0] w_s0;
            logic [BLOCK:0] w_s1;
            logic [BLOCK:0] w_blk;
            logic [SW-1:0]  w_s_nxt;

            logic           r_vld;
            logic [SW-1:0]  r_s;
            logic           r_c;

            if (k == 0) begin : g_src
                assign w_a_rem  = a;
                assign w_b_rem  = w_b_eff;
                assign w_ci     = w_c_eff;
                assign w_vld_in = w_in_xfer;
                assign w_s_nxt  = w_blk[BLOCK-1:0];
            end else begin : g_src
                assign w_a_rem  = g_stg[k-1].g_op.r_a;
                assign w_b_rem  = g_stg[k-1].g_op.r_b;
                assign w_ci     = g_stg[k-1].r_c;
                assign w_vld_in = g_stg[k-1].r_vld;
                assign w_s_nxt  = {w_blk[BLOCK-1:0], g_stg[k-1].r_s};
            end

            // Both carry hypotheses are computed in parallel; the registered
            // carry from the stage below only drives the final mux.
            assign w_s0  = {1'b0, w_a_rem[BLOCK-1:0]} + {1'b0, w_b_rem[BLOCK-1:0]};
            assign w_s1  = {1'b0, w_a_rem[BLOCK-1:0]} + {1'b0, w_b_rem[BLOCK-1:0]}
                         + {{BLOCK{1'b0}}, 1'b1};
            assign w_blk = w_ci ? w_s1 : w_s0;

            // Stage register: valid, finished low result bits and block carry-out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_s   <= '0;
                    r_c   <= 1'b0;
                end else if (!w_stall) begin
                    r_vld <= w_vld_in;
                    r_s   <= w_s_nxt;
                    r_c   <= w_blk[BLOCK];
                end
            end

            if (RW > BLOCK) begin : g_op
                logic [RW-BLOCK-1:0] r_a;
                logic [RW-BLOCK-1:0] r_b;

                // Carry the still-unprocessed upper operand bits to the next stage
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (!w_stall) begin
                        r_a <= w_a_rem[RW-1:BLOCK];
                        r_b <= w_b_rem[RW-1:BLOCK];
                    end
                end
            end else begin : g_last
                // Last stage: carry into the MSB recovered from the MSB sum bit,
                // XORed with the carry out gives signed overflow
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_ovf <= 1'b0;
                    end else if (!w_stall) begin
                        r_ovf <= w_a_rem[BLOCK-1] ^ w_b_rem[BLOCK-1]
                               ^ w_blk[BLOCK-1] ^ w_blk[BLOCK];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stg[NBLK-1].r_vld;
    assign sum       = g_stg[NBLK-1].r_s;
    assign cout      = g_stg[NBLK-1].r_c;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// tb_csa_pipe_adder: directed vectors on the 32/8 build plus a randomized
// sweep over four (WIDTH, BLOCK) builds checked against a behavioural model.
module tb_csa_pipe_adder;

    typedef struct packed {
        logic [1:0]  inst;
        logic [63:0] s;
        logic        co;
        logic        ov;
        int unsigned cyc;
        int unsigned stl;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  iv, ordy, scin, ssub;
    logic [63:0] sa [4];
    logic [63:0] sb [4];
    wire  [3:0]  ir, ov, sco, sov;
    logic [63:0] ssum [4];
    wire  [7:0]  sum8;
    wire  [15:0] sum16;
    wire  [31:0] sum32;
    wire  [63:0] sum64;

    int          n_chk;
    int          n_fail;
    logic        sb_en;
    exp_t        sbq [$];
    int unsigned stl [4];
    int unsigned acc [4];
    int unsigned cyc;

    assign ssum[0] = {56'd0, sum8};
    assign ssum[1] = {48'd0, sum16};
    assign ssum[2] = {32'd0, sum32};
    assign ssum[3] = sum64;

    csa_pipe_adder #(.WIDTH(8), .BLOCK(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(sa[0][7:0]), .b(sb[0][7:0]), .cin(scin[0]), .sub(ssub[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum8), .cout(sco[0]), .ovf(sov[0]));

    csa_pipe_adder #(.WIDTH(16), .BLOCK(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(sa[1][15:0]), .b(sb[1][15:0]), .cin(scin[1]), .sub(ssub[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum16), .cout(sco[1]), .ovf(sov[1]));

    csa_pipe_adder #(.WIDTH(32), .BLOCK(8)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(sa[2][31:0]), .b(sb[2][31:0]), .cin(scin[2]), .sub(ssub[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum32), .cout(sco[2]), .ovf(sov[2]));

    csa_pipe_adder #(.WIDTH(64), .BLOCK(16)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(sa[3]), .b(sb[3]), .cin(scin[3]), .sub(ssub[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .sum(sum64), .cout(sco[3]), .ovf(sov[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int i);
        case (i)
            0:       return 8;
            1:       return 16;
            2:       return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int nb_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Returns {cout, ovf, sum}; overflow from operand/result signs
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic su);
        logic [63:0] m, be, s;
        logic [64:0] full;
        logic        co, vf;
        m    = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        be   = (su ? ~b : b) & m;
        full = {1'b0, a & m} + {1'b0, be} + {64'd0, ci ^ su};
        s    = full[63:0] & m;
        co   = full[w];
        vf   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
        return {co, vf, s};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(7))
            0:       return {64{1'b1}};
            1:       return 64'd0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic su,
                         input logic [31:0] es, input logic eco, input logic eov);
        int lat;
        iv[2] = 1'b1; sa[2] = {32'd0, a}; sb[2] = {32'd0, b};
        scin[2] = ci; ssub[2] = su; ordy[2] = 1'b1;
        @(posedge clk); #1;
        iv[2] = 1'b0;
        lat = 1;
        while (!ov[2] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"},  64'(lat), 64'd4);
        chk({tag, "_sum"},  ssum[2], {32'd0, es});
        chk({tag, "_cout"}, 64'(sco[2]), 64'(eco));
        chk({tag, "_ovf"},  64'(sov[2]), 64'(eov));
        @(posedge clk); #1;
    endtask

    // Scoreboard for the random sweep: pop on output transfer, push on input transfer
    always @(negedge clk) begin
        int          fi;
        exp_t        e;
        logic [65:0] m;
        if (sb_en) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("sw%0d_irdy", width_of(i)), 64'(ir[i]), 64'(!(ov[i] && !ordy[i])));
                if (ov[i] && ordy[i]) begin
                    fi = -1;
                    for (int j = 0; j < sbq.size(); j++)
                        if (fi < 0 && sbq[j].inst == 2'(i)) fi = j;
                    if (fi < 0) begin
                        chk($sformatf("sw%0d_extra", width_of(i)), 64'd1, 64'd0);
                    end else begin
                        e = sbq[fi];
                        sbq.delete(fi);
                        chk($sformatf("sw%0d_sum", width_of(i)), ssum[i], e.s);
                        chk($sformatf("sw%0d_flags", width_of(i)), 64'({sco[i], sov[i]}), 64'({e.co, e.ov}));
                        chk($sformatf("sw%0d_lat", width_of(i)), 64'(cyc - e.cyc),
                            64'(32'(nb_of(i)) + stl[i] - e.stl));
                    end
                end
                if (ov[i] && !ordy[i]) stl[i]++;
                if (iv[i] && ir[i]) begin
                    m = model(width_of(i), sa[i], sb[i], scin[i], ssub[i]);
                    e.inst = 2'(i); e.s = m[63:0]; e.co = m[65]; e.ov = m[64];
                    e.cyc = cyc; e.stl = stl[i];
                    sbq.push_back(e);
                    acc[i]++;
                end
            end
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ba [10];
        logic [31:0] bb [10];
        logic        bc [10];
        logic        bs [10];
        logic [65:0] bexp [10];
        int          idx, oidx, budget;
        logic        took;

        n_chk = 0; n_fail = 0; sb_en = 1'b0; cyc = 0;
        for (int i = 0; i < 4; i++) begin
            sa[i] = '0; sb[i] = '0; stl[i] = 0; acc[i] = 0;
        end
        iv = '0; ordy = '1; scin = '0; ssub = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst%0d_ovld", width_of(i)), 64'(ov[i]), 64'd0);
            chk($sformatf("rst%0d_irdy", width_of(i)), 64'(ir[i]), 64'd1);
            chk($sformatf("rst%0d_sum", width_of(i)), ssum[i], 64'd0);
            chk($sformatf("rst%0d_flags", width_of(i)), 64'({sco[i], sov[i]}), 64'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, hand-computed
        run32("wrap",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run32("sub_b0",  32'd5,        32'd7,        1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run32("sub_b1",  32'd5,        32'd7,        1'b1, 1'b1, 32'hFFFFFFFD, 1'b0, 1'b0);
        run32("ovf_add", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run32("ovf_sub", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        run32("xblk",    32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0);
        run32("cin_add", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);
        run32("sub_eq",  32'd9,        32'd9,        1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);

        // Back-pressure: 10 back-to-back, out_ready low in cycles 6..8
        for (int k = 0; k < 10; k++) begin
            ba[k] = $urandom; bb[k] = $urandom;
            bc[k] = 1'($urandom_range(1)); bs[k] = 1'($urandom_range(1));
            bexp[k] = model(32, {32'd0, ba[k]}, {32'd0, bb[k]}, bc[k], bs[k]);
        end
        idx = 0; oidx = 0;
        for (int t = 0; t < 30; t++) begin
            ordy[2] = !(t >= 6 && t <= 8);
            iv[2]   = (idx < 10);
            if (idx < 10) begin
                sa[2] = {32'd0, ba[idx]}; sb[2] = {32'd0, bb[idx]};
                scin[2] = bc[idx]; ssub[2] = bs[idx];
            end
            @(negedge clk);
            chk("bp_irdy", 64'(ir[2]), 64'(t < 6 || t > 8));
            if (t >= 6 && t <= 8) begin
                chk("bp_stall_vld", 64'(ov[2]), 64'd1);
                if (oidx < 10) chk("bp_hold", ssum[2], bexp[oidx][63:0]);
            end
            if (ov[2] && ordy[2]) begin
                if (oidx < 10) begin
                    chk("bp_sum", ssum[2], bexp[oidx][63:0]);
                    chk("bp_flags", 64'({sco[2], sov[2]}), 64'(bexp[oidx][65:64]));
                end
                oidx++;
            end
            took = iv[2] && (t < 6 || t > 8);
            @(posedge clk); #1;
            if (took) idx++;
        end
        chk("bp_count", 64'(oidx), 64'd10);
        chk("bp_drained", 64'(ov[2]), 64'd0);
        ordy[2] = 1'b1;

        // Reset with three transactions in flight
        for (int k = 0; k < 3; k++) begin
            iv[2] = 1'b1; sa[2] = 64'h1000 + 64'(k); sb[2] = 64'h2000;
            scin[2] = 1'b0; ssub[2] = 1'b0;
            @(posedge clk); #1;
        end
        iv[2] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_vld", 64'(ov[2]), 64'd1);
        chk("rst_pre_sum", ssum[2], 64'h3000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_vld",   64'(ov[2]), 64'd0);
        chk("rst_mid_sum",   ssum[2], 64'd0);
        chk("rst_mid_flags", 64'({sco[2], sov[2]}), 64'd0);
        chk("rst_mid_irdy",  64'(ir[2]), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rst_stale", 64'(ov[2]), 64'd0);
            @(posedge clk); #1;
        end
        run32("post_rst", 32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0, 32'hDFAEBFF0, 1'b0, 1'b0);

        // Random sweep across all four builds
        sb_en = 1'b1;
        budget = 0;
        while ((acc[0] < 1000 || acc[1] < 1000 || acc[2] < 1000 || acc[3] < 1000)
               && budget < 20000) begin
            for (int i = 0; i < 4; i++) begin
                iv[i]   = (acc[i] < 1000) && ($urandom_range(3) != 0);
                sa[i]   = rnd64();
                sb[i]   = rnd64();
                scin[i] = 1'($urandom_range(1));
                ssub[i] = 1'($urandom_range(1));
                ordy[i] = ($urandom_range(3) != 0);
            end
            @(posedge clk); #1;
            budget++;
        end
        chk("sw_budget", 64'(budget < 20000), 64'd1);
        iv = '0; ordy = '1;
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            chk($sformatf("sw%0d_accepted", width_of(i)), 64'(acc[i]), 64'd1000);
        chk("sw_left", 64'(sbq.size()), 64'd0);
        @(negedge clk);
        sb_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
